// File: rtl/diablo_decode_pkg.sv
// diablo_decode_pkg: shared types and opcode constants for the decode stage
package diablo_decode_pkg;
  localparam int XLEN = 64;
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;
endpackage

// File: rtl/decode_classify.sv
// decode_classify: combinational opcode-to-format classifier and immediate extractor
module decode_classify
  import diablo_decode_pkg::*;
(
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [31:0] imm32;
  // every valid opcode ends in 2'b11, so a bad low pair falls through to NONE
  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      OPC_OP, OPC_OP32:                          fmt = FMT_R;
      OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                                 fmt = FMT_S;
      OPC_BRANCH:                                fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
      OPC_JAL:                                   fmt = FMT_J;
      default:                                   fmt = FMT_NONE;
    endcase
  end
  // build a 32-bit sign-extended immediate per format; R and NONE stay zero
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm     = {{(XLEN-32){imm32[31]}}, imm32};
  assign illegal = (fmt == FMT_NONE);
endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: decode-stage two-entry skid buffer with push-time classification (optional DECODE_PERF_CNT_EN perf counters)
module decode_issue_ctrl
  import diablo_decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [2:0]      out_fmt_o,
  output logic            out_illegal_o
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_decoded_o,
  output logic [31:0]     perf_stall_o
`endif
);
  buf_state_e      state, state_nxt;
  entry_t          head, skid, new_e;
  fmt_e            new_fmt;
  logic [XLEN-1:0] new_imm;
  logic            new_ill, push, pop;
  decode_classify u_cls (
    .instr   (in_instr_i),
    .fmt     (new_fmt),
    .imm     (new_imm),
    .illegal (new_ill)
  );
  assign new_e       = '{in_instr_i, in_pc_i, new_imm, new_fmt, new_ill};
  assign in_ready_o  = (state != ST_FULL);
  assign out_valid_o = (state != ST_EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  // buffer occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end
  // occupancy transitions; flush overrides any same-cycle push or pop
  always_comb begin
    state_nxt = flush_i            ? ST_EMPTY :
                state == ST_EMPTY  ? (push ? ST_ONE : ST_EMPTY) :
                state == ST_ONE    ? (push == pop ? ST_ONE : push ? ST_FULL : ST_EMPTY) :
                state == ST_FULL   ? (pop ? ST_ONE : ST_FULL) : ST_EMPTY;
  end
  // head holds the oldest entry; skid absorbs the in-flight push when execute stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (pop && state == ST_FULL)                 head <= skid;
      else if (push && (state == ST_EMPTY || pop)) head <= new_e;
      if (push && !pop && state == ST_ONE)         skid <= new_e;
    end
  end
  assign out_instr_o   = head.instr;
  assign out_pc_o      = head.pc;
  assign out_imm_o     = head.imm;
  assign out_fmt_o     = head.fmt;
  assign out_illegal_o = head.illegal;
`ifdef DECODE_PERF_CNT_EN
  // saturating counters of pops and fetch stall cycles, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (pop && perf_decoded_o != '1)                    perf_decoded_o <= perf_decoded_o + 32'd1;
      if (in_valid_i && !in_ready_o && perf_stall_o != '1) perf_stall_o   <= perf_stall_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: scoreboard bench for decode_issue_ctrl with a spec-level reference model
module tb_decode_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_instr_i = '0;
  logic [63:0] in_pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_instr_o;
  logic [63:0] out_pc_o;
  logic [63:0] out_imm_o;
  logic [2:0]  out_fmt_o;
  logic        out_illegal_o;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded_o, perf_stall_o;
  logic [31:0] exp_dec = '0, exp_stall = '0;
`endif
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;
  exp_t        q[$];
  int          n_chk = 0, n_fail = 0;
  logic [63:0] pc_ctr = 64'h8000_0000;
  logic [6:0]  ops [11] = '{7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

  decode_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
    .out_pc_o(out_pc_o), .out_imm_o(out_imm_o), .out_fmt_o(out_fmt_o), .out_illegal_o(out_illegal_o)
`ifdef DECODE_PERF_CNT_EN
    , .perf_decoded_o(perf_decoded_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sext(input longint f, input int n);
    return (f >= (64'sd1 <<< (n - 1))) ? f - (64'sd1 <<< n) : f;
  endfunction

  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t e;
    logic [6:0] op = w[6:0];
    e.instr = w; e.pc = pc; e.fmt = 3'd7; e.imm = '0; e.ill = 1'b1;
    if (op == 7'h33 || op == 7'h3b) e.fmt = 3'd0;
    else if (op == 7'h13 || op == 7'h1b || op == 7'h03 || op == 7'h67) begin
      e.fmt = 3'd1; e.imm = sext(longint'(w[31:20]), 12);
    end else if (op == 7'h23) begin
      e.fmt = 3'd2; e.imm = sext(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
    end else if (op == 7'h63) begin
      e.fmt = 3'd3;
      e.imm = sext(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
    end else if (op == 7'h37 || op == 7'h17) begin
      e.fmt = 3'd4; e.imm = sext(longint'(w[31:12]) * 4096, 32);
    end else if (op == 7'h6f) begin
      e.fmt = 3'd5;
      e.imm = sext(longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * (1 << 12) + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
    end
    if (e.fmt != 3'd7) e.ill = 1'b0;
    return e;
  endfunction

  // monitor: checks handshake levels against queue occupancy and pops expected entries
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
`ifdef DECODE_PERF_CNT_EN
      exp_dec = '0; exp_stall = '0;
`endif
    end else begin
`ifdef DECODE_PERF_CNT_EN
      chk(perf_decoded_o == exp_dec, "perf_decoded", perf_decoded_o, exp_dec);
      chk(perf_stall_o == exp_stall, "perf_stall", perf_stall_o, exp_stall);
      if (out_valid_o && out_ready_i && exp_dec != '1) exp_dec++;
      if (in_valid_i && !in_ready_o && exp_stall != '1) exp_stall++;
`endif
      chk(in_ready_o == (q.size() < 2), "in_ready", 64'(in_ready_o), 64'(q.size() < 2));
      chk(out_valid_o == (q.size() > 0), "out_valid", 64'(out_valid_o), 64'(q.size() > 0));
      if (out_valid_o && out_ready_i && q.size() > 0) begin
        e = q.pop_front();
        chk(out_instr_o == e.instr, "pop_instr", out_instr_o, e.instr);
        chk(out_pc_o == e.pc, "pop_pc", out_pc_o, e.pc);
        chk(out_imm_o == e.imm, "pop_imm", out_imm_o, e.imm);
        chk(out_fmt_o == e.fmt, "pop_fmt", 64'(out_fmt_o), 64'(e.fmt));
        chk(out_illegal_o == e.ill, "pop_illegal", 64'(out_illegal_o), 64'(e.ill));
      end
      if (flush_i) q.delete();
      else if (in_valid_i && in_ready_o) q.push_back(model(in_instr_i, in_pc_i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bit ok = 1'b0;
    in_valid_i = 1'b1; in_instr_i = w; in_pc_i = pc_ctr; pc_ctr += 4;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = in_ready_o;
      step();
    end
    if (!ok) chk(1'b0, "send_timeout", 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int i = 0; i < 50 && out_valid_o; i++) step();
    chk(out_valid_o == 1'b0, "drain", 64'(out_valid_o), 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk(out_valid_o == 1'b0 && in_ready_o == 1'b1, {tag, "_hs"}, {62'd0, out_valid_o, in_ready_o}, 64'd1);
    chk(out_instr_o == '0 && out_pc_o == '0 && out_imm_o == '0 && out_fmt_o == '0 && out_illegal_o == 1'b0,
        {tag, "_data"}, out_pc_o | out_imm_o | 64'(out_instr_o) | 64'(out_fmt_o) | 64'(out_illegal_o), 64'd0);
`ifdef DECODE_PERF_CNT_EN
    chk(perf_decoded_o == '0 && perf_stall_o == '0, {tag, "_perf"}, {perf_decoded_o, perf_stall_o}, 64'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    #12;
    chk_zero_outputs("reset");
    step();
    rst_n = 1'b1;
    // single ADDI: visible one cycle after the push
    out_ready_i = 1'b0;
    send(32'hFFF0_0093);
    chk(out_valid_o == 1'b1, "addi_valid", 64'(out_valid_o), 64'd1);
    chk(out_fmt_o == 3'd1, "addi_fmt", 64'(out_fmt_o), 64'd1);
    chk(out_imm_o == 64'hFFFF_FFFF_FFFF_FFFF, "addi_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk(out_illegal_o == 1'b0, "addi_illegal", 64'(out_illegal_o), 64'd0);
    drain();
    // back-to-back BEQ and JAL with execute ready
    out_ready_i = 1'b1;
    send(32'hFE00_0EE3);
    chk(out_imm_o == 64'hFFFF_FFFF_FFFF_FFFC, "beq_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    send(32'h0000_006F);
    chk(out_imm_o == 64'd0 && out_fmt_o == 3'd5, "jal_imm", out_imm_o, 64'd0);
    drain();
    // back-pressure: two fill the buffer, third is held by fetch
    out_ready_i = 1'b0;
    send(32'h0010_0093);
    send(32'h0020_0113);
    chk(in_ready_o == 1'b0, "full_ready", 64'(in_ready_o), 64'd0);
    in_valid_i = 1'b1; in_instr_i = 32'h0030_0193; in_pc_i = pc_ctr;
    repeat (3) step();
    chk(in_ready_o == 1'b0, "stall_ready", 64'(in_ready_o), 64'd0);
    out_ready_i = 1'b1;
    send(32'h0030_0193);
    drain();
    // illegal encodings
    send(32'hFFFF_FFFF);
    chk(out_illegal_o == 1'b1 && out_fmt_o == 3'd7 && out_imm_o == '0, "ill_ones", out_imm_o, 64'd0);
    send(32'h0000_0000);
    chk(out_illegal_o == 1'b1 && out_fmt_o == 3'd7 && out_imm_o == '0, "ill_zero", out_imm_o, 64'd0);
    drain();
    // flush while full with a pending fetch
    out_ready_i = 1'b0;
    send(32'h0040_0213);
    send(32'h0050_0293);
    in_valid_i = 1'b1; in_instr_i = 32'h0060_0313; in_pc_i = 64'hDEAD_0000; flush_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk(out_valid_o == 1'b0, "flush_valid", 64'(out_valid_o), 64'd0);
    chk(in_ready_o == 1'b1, "flush_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    step();
    // asynchronous reset while one entry is held
    out_ready_i = 1'b0;
    send(32'h0070_0393);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    step();
    rst_n = 1'b1;
    step();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w = $urandom;
      if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(10)];
      in_valid_i  = ($urandom_range(3) != 0);
      out_ready_i = ($urandom_range(2) != 0);
      flush_i     = ($urandom_range(49) == 0);
      in_instr_i  = w;
      in_pc_i     = {$urandom, $urandom};
      step();
    end
    flush_i = 1'b0; in_valid_i = 1'b0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Decode-stage issue controller for the core, placed between instruction fetch and the register-read/execute stages. It accepts fetched instructions over a valid/ready handshake and classifies each opcode into an instruction format. It produces a sign-extended XLEN immediate and an illegal flag for every instruction, and holds results in a two-entry skid buffer so fetch never sees a combinational ready path from execute.

## Interface
- XLEN, 64: datapath width for PC and immediate.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- flush_i  in  1  discard all buffered entries (branch/trap redirect).
- in_valid_i  in  1  fetch has an instruction.
- in_ready_o  out  1  decode can accept.
- in_instr_i  in  32  instruction word.
- in_pc_i  in  XLEN  instruction PC.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  execute accepts head.
- out_instr_o  out  32  head instruction.
- out_pc_o  out  XLEN  head PC.
- out_imm_o  out  XLEN  head immediate.
- out_fmt_o  out  3  head format (fmt_e).
- out_illegal_o  out  1  head is illegal.
- perf_decoded_o  out  32  only with DECODE_PERF_CNT_EN.
- perf_stall_o  out  32  only with DECODE_PERF_CNT_EN.

## Operation
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- Classification is done at push time; fields are stored in the buffer. Outputs come from the head entry, so order is FIFO.
- Formats: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- Opcode to format mapping:
  - 0110011, 0111011 → R.
  - 0010011, 0011011, 0000011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Anything else, or instr[1:0]≠2'b11 → NONE with illegal=1.
- Immediates are sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R and NONE: all zeros. X is never driven.
- Buffer state machine:
  - EMPTY: push → ONE.
  - ONE: push and pop → ONE; push only → FULL; pop only → EMPTY.
  - FULL: pop → ONE; push is impossible because in_ready_o=0.
- in_ready_o = (state≠FULL), decoded from the state register only.
- out_valid_o = (state≠EMPTY).
- flush_i has priority: the next state is EMPTY. A push or pop in the same cycle is discarded, although the handshake signals still complete.
- Reset values: state EMPTY, in_ready_o=1, out_valid_o=0, all data outputs 0, perf counters 0.
- Asserting rst_n low mid-operation drops all entries immediately.

## Timing
- Latency: an instruction pushed at edge N appears on the outputs after edge N. out_valid_o is high during cycle N+1.
- Throughput: one instruction per cycle while out_ready_i=1.
- Back-pressure:
  - in_ready_o falls one cycle after the buffer fills.
  - The skid entry absorbs the instruction that was in flight.
- Head outputs are stable while out_valid_o=1 and out_ready_i=0.

## Configuration
- Macro: DECODE_PERF_CNT_EN.
- Defined:
  - perf_decoded_o increments on every pop.
  - perf_stall_o increments each cycle with in_valid_i=1 and in_ready_o=0.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared by reset only; flush_i does not clear them.
- Undefined: both ports and all counter logic are absent.

## Structure
- Package diablo_decode_pkg holds:
  - fmt_e enum (3-bit).
  - Opcode localparams (OPC_OP, OPC_OP32, OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL).
  - Buffer state enum.
  - Buffer entry struct.
- Sub-module decode_classify is purely combinational: instruction in; fmt, imm and illegal out. It is instantiated once, on the push path.

## Test plan
- Reset, then push ADDI 0xFFF00093 → after 1 cycle: out_valid_o=1, fmt=I, imm=0xFFFF_FFFF_FFFF_FFFF, illegal=0.
- Push BEQ 0xFE000EE3 and JAL 0x0000006F back to back with out_ready_i=1:
  - Two consecutive pops in order.
  - BEQ imm=0xFFFF_FFFF_FFFF_FFFC; JAL imm=0.
- Hold out_ready_i=0 and push three instructions:
  - in_ready_o=0 after the second push; the third is held by fetch.
  - Release: all three pop in order. With DECODE_PERF_CNT_EN, perf_stall_o counts the stalled cycles exactly.
- Push 0xFFFFFFFF and 0x00000000 → both fmt=NONE, illegal=1, imm=0.
- While FULL, assert flush_i together with in_valid_i=1 → next cycle out_valid_o=0 and in_ready_o=1; the flushed instruction never appears.
- Assert rst_n low while in state ONE → out_valid_o=0 immediately, without waiting for a clock edge; all outputs 0.
